seg7_capture: RTL and testbench

SEG7_CAPTURE -- requirements
Module: seg7_capture

---
 rtl/seg7_pkg.sv | 21 ++
 rtl/seg7_decode.sv | 23 ++
 rtl/seg7_capture.sv | 116 +++++++++++
 tb/tb_seg7_capture.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared seven-segment patterns and capture FSM states
package seg7_pkg;

  localparam logic [6:0] BLANK = 7'b0000000;

  // Segment order abcdefg, bit6 = a; index is the hex value shown.
  localparam logic [6:0] HEX_PAT [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    LATCH,
    HOLD
  } state_t;

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational segment pattern to hex value decoder
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] value,
  output logic       hit,
  output logic       blank
);

  always_comb begin
    value = 4'h0;
    hit   = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (seg == HEX_PAT[i]) begin
        value = 4'(i);
        hit   = 1'b1;
      end
    end
    blank = (seg == BLANK);
  end

endmodule

// File: rtl/seg7_capture.sv
// rtl/seg7_capture.sv - captures two hex digits from a multiplexed 7-segment bus
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 1000,
  parameter int CNT_W         = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_in,
  input  logic       sel_in,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic       valid0,
  output logic       valid1,
  output logic       blank0,
  output logic       blank1,
  output logic       upd,
  output logic       err
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [7:0]       sync1;
  logic [7:0]       w;
  logic [7:0]       w_prev;
  logic [CNT_W-1:0] cnt;
  state_t           state;

  logic [3:0] dec_value;
  logic       dec_hit;
  logic       dec_blank;

  seg7_decode u_decode (
    .seg   (w[6:0]),
    .value (dec_value),
    .hit   (dec_hit),
    .blank (dec_blank)
  );

  // Outputs are written on the edge that enters LATCH, so upd and the new
  // digit values are visible during the single LATCH cycle itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 8'h00;
      w      <= 8'h00;
      w_prev <= 8'h00;
      cnt    <= '0;
      state  <= IDLE;
      digit0 <= 4'h0;
      digit1 <= 4'h0;
      valid0 <= 1'b0;
      valid1 <= 1'b0;
      blank0 <= 1'b0;
      blank1 <= 1'b0;
      upd    <= 1'b0;
      err    <= 1'b0;
    end else begin
      sync1  <= {sel_in, seg_in};
      w      <= sync1;
      w_prev <= w;
      upd    <= 1'b0;
      case (state)
        IDLE: begin
          cnt   <= '0;
          state <= SETTLE;
        end
        SETTLE: begin
          if (w != w_prev) begin
            cnt <= '0;
          end else begin
            if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
            if (cnt == CNT_LAST) begin
              state <= LATCH;
              upd   <= 1'b1;
              if (dec_hit) begin
                if (w[7]) begin
                  digit1 <= dec_value;
                  valid1 <= 1'b1;
                  blank1 <= 1'b0;
                end else begin
                  digit0 <= dec_value;
                  valid0 <= 1'b1;
                  blank0 <= 1'b0;
                end
              end else if (dec_blank) begin
                if (w[7]) blank1 <= 1'b1;
                else      blank0 <= 1'b1;
              end else begin
                err <= 1'b1;
              end
            end
          end
        end
        // A change seen here would vanish from w/w_prev before HOLD, so restart now.
        LATCH: begin
          if (w != w_prev) begin
            cnt   <= '0;
            state <= SETTLE;
          end else begin
            state <= HOLD;
          end
        end
        HOLD: begin
          if (w != w_prev) begin
            cnt   <= '0;
            state <= SETTLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_capture.sv
// tb/tb_seg7_capture.sv - directed self-checking bench for seg7_capture
module tb_seg7_capture;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] seg_in = 7'b0;
  logic       sel_in = 1'b0;
  logic [3:0] digit0, digit1;
  logic       valid0, valid1, blank0, blank1, upd, err;

  int checks = 0;
  int failures = 0;
  int upd_cnt = 0;

  seg7_capture #(.STABLE_CYCLES(4), .CNT_W(16)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .seg_in (seg_in),
    .sel_in (sel_in),
    .digit0 (digit0),
    .digit1 (digit1),
    .valid0 (valid0),
    .valid1 (valid1),
    .blank0 (blank0),
    .blank1 (blank1),
    .upd    (upd),
    .err    (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (upd) upd_cnt <= upd_cnt + 1;

  typedef struct {
    logic       sel;
    logic [6:0] seg;
    logic [3:0] d0;
    logic [3:0] d1;
    logic       v0, v1, b0, b1, e;
  } vec_t;

  vec_t tbl[8];

  function automatic logic [12:0] pack_exp(vec_t v);
    return {v.d0, v.d1, v.v0, v.v1, v.b0, v.b1, v.e};
  endfunction

  function automatic logic [12:0] pack_dut();
    return {digit0, digit1, valid0, valid1, blank0, blank1, err};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Returns the number of clock edges until upd is seen, or 99 on timeout.
  task automatic wait_upd(output int k);
    k = 99;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (upd) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int k;
    int c0;
    vec_t ex;

    tbl[0] = '{1'b0, 7'b0110000, 4'h1, 4'h3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 7'b1011011, 4'h1, 4'h5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 7'b1110000, 4'h7, 4'h5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 7'b0000000, 4'h7, 4'h5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 7'b1010101, 4'h7, 4'h5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{1'b1, 7'b1110111, 4'h7, 4'hA, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 7'b0011111, 4'hB, 4'hA, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{1'b1, 7'b0000000, 4'hB, 4'hA, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    // Reset state, then digit1 = 3 accepted 7 cycles after release
    sel_in = 1'b1;
    seg_in = 7'b1111001;
    idle_cycles(3);
    check("reset_outputs", {19'b0, pack_dut()}, 32'h0);
    check("reset_upd", {31'b0, upd}, 32'h0);
    rst_n = 1'b1;
    wait_upd(k);
    check("first_latency", k, 7);
    ex = '{1'b1, 7'b1111001, 4'h0, 4'h3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    check("first_outputs", {19'b0, pack_dut()}, {19'b0, pack_exp(ex)});
    idle_cycles(12);

    for (int i = 0; i < 8; i++) begin
      c0 = upd_cnt;
      sel_in = tbl[i].sel;
      seg_in = tbl[i].seg;
      wait_upd(k);
      check($sformatf("vec%0d_latency", i), k, 7);
      check($sformatf("vec%0d_outputs", i), {19'b0, pack_dut()}, {19'b0, pack_exp(tbl[i])});
      idle_cycles(12);
      check($sformatf("vec%0d_upd_count", i), upd_cnt - c0, 1);
    end

    // Short-lived patterns never accepted; the final stable one is accepted once
    c0 = upd_cnt;
    sel_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      seg_in = (i % 2 == 0) ? 7'b1000111 : 7'b1001111;
      idle_cycles(3);
    end
    idle_cycles(1);
    check("toggle_no_upd", upd_cnt - c0, 0);
    idle_cycles(20);
    check("toggle_then_stable_upd", upd_cnt - c0, 1);
    ex = '{1'b1, 7'b1001111, 4'hB, 4'hE, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    check("toggle_outputs", {19'b0, pack_dut()}, {19'b0, pack_exp(ex)});

    // Change reaching w during the LATCH cycle: first latch completes, then re-settle
    c0 = upd_cnt;
    seg_in = 7'b0110011;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
    seg_in = 7'b1111111;
    wait_upd(k);
    check("latch_change_first_k", k, 2);
    check("latch_change_digit1_a", {28'b0, digit1}, 32'h4);
    wait_upd(k);
    check("latch_change_second_k", k, 5);
    check("latch_change_digit1_b", {28'b0, digit1}, 32'h8);
    idle_cycles(12);
    check("latch_change_upd_count", upd_cnt - c0, 2);

    // Reset two cycles before acceptance aborts it; full latency after release
    c0 = upd_cnt;
    sel_in = 1'b0;
    seg_in = 7'b1111110;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    check("midsettle_reset_outputs", {19'b0, pack_dut()}, 32'h0);
    idle_cycles(3);
    check("midsettle_reset_upd", {31'b0, upd}, 32'h0);
    check("midsettle_no_upd", upd_cnt - c0, 0);
    rst_n = 1'b1;
    wait_upd(k);
    check("post_reset_latency", k, 7);
    ex = '{1'b0, 7'b1111110, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    check("post_reset_outputs", {19'b0, pack_dut()}, {19'b0, pack_exp(ex)});
    idle_cycles(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
